// File: rtl/imem_load_if.sv
// Loader / instruction-memory bus between the boot stream source, the IF stage
// and the instruction memory.
//   slave  : controller side (imem_load_ctrl)
//   master : environment side (stream source, IF-stage PC, memory)
// Signals:
//   in_valid/in_data/in_ready : byte stream with valid/ready handshake
//   reload                    : one-cycle restart request
//   fetch_addr                : IF-stage PC
//   mem_addr/mem_we/mem_wdata : instruction memory port
//   cpu_hold                  : pipeline freeze
//   load_done/load_err        : load status
`timescale 1ns/1ps
interface imem_load_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  in_valid, in_data, reload, fetch_addr,
    output in_ready, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_err
  );

  modport master (
    output in_valid, in_data, reload, fetch_addr,
    input  in_ready, mem_addr, mem_we, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot/reload controller for the byte-wide instruction memory.
// Accepts a frame CNT_HI, CNT_LO, N payload bytes, CHK over a valid/ready byte
// stream, writes the payload from address 0 upward through one registered
// write stage, verifies the 8-bit additive checksum and then releases the CPU.
// Owns the memory address mux: loader pointer while loading, fetch_addr in RUN.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : imem_load_if.slave (stream, reload, fetch/memory port, status)
//
// state  | meaning
// HDR_HI | waiting for byte-count high byte
// HDR_LO | waiting for byte-count low byte, header validated here
// LOAD   | streaming payload bytes into memory
// CHK    | waiting for checksum byte
// RUN    | CPU running, memory address follows fetch_addr
// ERR    | fault seen, CPU held, waits for reload
`timescale 1ns/1ps
module imem_load_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  imem_load_if.slave  bus
);

  // One extra bit so the pointer can reach MEM_BYTES after a full load without wrapping.
  localparam int PTR_W = $clog2(MEM_BYTES) + 1;

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  wptr;
  logic [7:0]        sum;
  logic              we_q;
  logic [7:0]        wdata_q;
  logic              done_q;

  logic              rdy;
  logic              accept;
  logic [CNT_W-1:0]  hdr_n;
  logic              hdr_bad;
  logic              sum_ok;
  logic              hold;
  logic [ADDR_W-1:0] addr_mux;

  assign rdy     = (state != S_RUN) && (state != S_ERR);
  assign accept  = bus.in_valid && rdy;
  assign hdr_n   = {cnt[CNT_W-1:8], bus.in_data};
  assign hdr_bad = (32'(hdr_n) > 32'(MEM_BYTES)) || (hdr_n[1:0] != 2'b00);
  assign sum_ok  = (bus.in_data == sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold      = 1'b1;
    addr_mux  = ADDR_W'(wptr);
    case (state)
      S_HDR_HI: begin
        if (accept) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (accept) begin
          if (hdr_bad)             state_nxt = S_ERR;
          else if (hdr_n == '0)    state_nxt = S_CHK;
          else                     state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // cnt holds the bytes still expected; the accept at cnt==1 is the last one.
        if (accept && (cnt == CNT_W'(1))) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (accept) state_nxt = sum_ok ? S_RUN : S_ERR;
      end
      S_RUN: begin
        hold     = 1'b0;
        addr_mux = bus.fetch_addr;
        if (bus.reload) state_nxt = S_HDR_HI;
      end
      S_ERR: begin
        if (bus.reload) state_nxt = S_HDR_HI;
      end
      default: begin
        state_nxt = S_HDR_HI;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      wptr    <= '0;
      sum     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      // The pointer advances at the end of each write cycle, so the write
      // currently on the bus uses the pre-increment value.
      if (we_q) wptr <= wptr + PTR_W'(1);
      case (state)
        S_HDR_HI: begin
          if (accept) cnt <= CNT_W'({bus.in_data, 8'h00});
        end
        S_HDR_LO: begin
          if (accept) cnt <= hdr_n;
        end
        S_LOAD: begin
          if (accept) begin
            we_q    <= 1'b1;
            wdata_q <= bus.in_data;
            sum     <= sum + bus.in_data;
            cnt     <= cnt - CNT_W'(1);
          end
        end
        S_CHK: begin
          if (accept && sum_ok) done_q <= 1'b1;
        end
        S_RUN, S_ERR: begin
          if (bus.reload) begin
            cnt  <= '0;
            wptr <= '0;
            sum  <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold;
  assign bus.load_done = done_q;
  assign bus.load_err  = (state == S_ERR);

endmodule

// File: tb/tb_imem_load_ctrl.sv
`timescale 1ns/1ps
module tb_imem_load_ctrl;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_load_if #(.ADDR_W(ADDR_W)) bus();

  imem_load_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] wr_a[$];
  logic [7:0]        wr_d[$];
  int                exp_a[$];
  logic [7:0]        exp_d[$];
  bit                exp_err;
  int                exp_send;
  int                done_cnt = 0;
  int                bad_we   = 0;
  bit                prev_acc = 0;

  // Write/status monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 0;
    end else begin
      if (bus.mem_we) begin
        wr_a.push_back(bus.mem_addr);
        wr_d.push_back(bus.mem_wdata);
        if (!prev_acc) bad_we++;
      end
      if (bus.load_done) done_cnt++;
      prev_acc = bus.in_valid && bus.in_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    bad_we   = 0;
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    int s;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(n / 256));
    frame.push_back(8'(n % 256));
    s = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame.push_back(b);
      s += int'(b);
    end
    if (corrupt) frame.push_back(8'((s + 1 + $urandom_range(0, 254)) % 256));
    else         frame.push_back(8'(s % 256));
  endtask

  // Reference model: expected writes and final status derived from the frame rules.
  task automatic model_frame();
    int n;
    int s;
    exp_a.delete();
    exp_d.delete();
    n = int'(frame[0]) * 256 + int'(frame[1]);
    if (n > MEM_BYTES || (n % 4) != 0) begin
      exp_err  = 1;
      exp_send = 2;
      return;
    end
    s = 0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(frame[2 + i]);
      s += int'(frame[2 + i]);
    end
    exp_err  = (int'(frame[2 + n]) != (s % 256));
    exp_send = n + 3;
  endtask

  // gaps: 0 back-to-back, 1 one idle cycle before each byte, 2 random 0..2 idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gaps, output bit ok);
    int idle;
    int guard;
    idle = (gaps == 0) ? 0 : (gaps == 1) ? 1 : int'($urandom_range(0, 2));
    bus.in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok    = 0;
    guard = 0;
    while (!ok && guard < 20) begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    @(posedge clk); #1;
    bus.reload = 1'b0;
  endtask

  task automatic run_frame(input string name, input int gaps);
    bit ok;
    int first_bad;
    int nmin;
    model_frame();
    clear_logs();
    for (int i = 0; i < exp_send; i++) begin
      send_byte(frame[i], gaps, ok);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL %s accept: byte %0d not accepted within 20 cycles", name, i);
        break;
      end
    end
    repeat (2) begin @(posedge clk); #1; end

    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL %s in_ready: got %b want 0", name, bus.in_ready);
    end
    n_cmp++;
    if (bus.load_err !== exp_err) begin
      n_bad++; $display("FAIL %s load_err: got %b want %b", name, bus.load_err, exp_err);
    end
    n_cmp++;
    if (bus.cpu_hold !== exp_err) begin
      n_bad++; $display("FAIL %s cpu_hold: got %b want %b", name, bus.cpu_hold, exp_err);
    end
    n_cmp++;
    if (done_cnt !== (exp_err ? 0 : 1)) begin
      n_bad++; $display("FAIL %s load_done pulses: got %0d want %0d", name, done_cnt, exp_err ? 0 : 1);
    end
    n_cmp++;
    if (wr_a.size() !== exp_a.size()) begin
      n_bad++; $display("FAIL %s write count: got %0d want %0d", name, wr_a.size(), exp_a.size());
    end
    first_bad = -1;
    nmin = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
    for (int i = 0; i < nmin; i++) begin
      if (wr_a[i] !== ADDR_W'(exp_a[i]) || wr_d[i] !== exp_d[i]) begin
        first_bad = i;
        break;
      end
    end
    n_cmp++;
    if (first_bad >= 0) begin
      n_bad++;
      $display("FAIL %s write %0d: got addr %0d data %02h want addr %0d data %02h", name,
               first_bad, wr_a[first_bad], wr_d[first_bad], exp_a[first_bad], exp_d[first_bad]);
    end
    n_cmp++;
    if (bad_we !== 0) begin
      n_bad++; $display("FAIL %s mem_we without prior accept: got %0d cycles want 0", name, bad_we);
    end
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin
      n_bad++; $display("FAIL %s idle mem_we: got %b want 0", name, bus.mem_we);
    end
    n_cmp++;
    if (exp_err) begin
      if (bus.mem_addr !== ADDR_W'(exp_a.size())) begin
        n_bad++; $display("FAIL %s err mem_addr: got %0d want %0d", name, bus.mem_addr, exp_a.size());
      end
    end else begin
      if (bus.mem_addr !== bus.fetch_addr) begin
        n_bad++; $display("FAIL %s run mem_addr: got %h want %h", name, bus.mem_addr, bus.fetch_addr);
      end
    end
  endtask

  task automatic check_loader_idle(input string name);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_err !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.load_done !== 1'b0 || bus.mem_addr !== '0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b hold=%b err=%b we=%b done=%b addr=%0d want 1 1 0 0 0 0", name,
               bus.in_ready, bus.cpu_hold, bus.load_err, bus.mem_we, bus.load_done, bus.mem_addr);
    end
  endtask

  task automatic set_fixed_frame();
    logic [7:0] f [11];
    // Payload sums to 0xF6 mod 256.
    f = '{8'h00, 8'h08, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, 8'hF6};
    frame.delete();
    foreach (f[i]) frame.push_back(f[i]);
  endtask

  task automatic test_reset();
    #3;
    check_loader_idle("reset");
    n_cmp++;
    if (bus.mem_wdata !== 8'h00) begin
      n_bad++; $display("FAIL reset mem_wdata: got %h want 00", bus.mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.fetch_addr = 32'h4;
    set_fixed_frame();
    run_frame("basic", 0);
  endtask

  task automatic test_toggle();
    pulse_reload();
    set_fixed_frame();
    run_frame("toggle", 1);
  endtask

  task automatic test_hdr_err();
    pulse_reload();
    frame.delete(); frame.push_back(8'h04); frame.push_back(8'h04); frame.push_back(8'h00);
    run_frame("hdr_1028", 0);
    pulse_reload();
    frame.delete(); frame.push_back(8'h00); frame.push_back(8'h06); frame.push_back(8'h00);
    run_frame("hdr_partial", 0);
  endtask

  task automatic test_bad_chk();
    pulse_reload();
    frame.delete();
    frame.push_back(8'h00); frame.push_back(8'h04);
    frame.push_back(8'h01); frame.push_back(8'h02); frame.push_back(8'h03); frame.push_back(8'h04);
    frame.push_back(8'h0B);
    run_frame("bad_chk", 2);
    pulse_reload();
    check_loader_idle("reload_from_err");
  endtask

  task automatic test_empty_and_reload();
    pulse_reload();
    frame.delete(); frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h00);
    run_frame("empty", 0);
    bus.fetch_addr = $urandom;
    #1;
    n_cmp++;
    if (bus.mem_addr !== bus.fetch_addr) begin
      n_bad++; $display("FAIL fetch_passthru: got %h want %h", bus.mem_addr, bus.fetch_addr);
    end
    @(posedge clk); #1;
    pulse_reload();
    check_loader_idle("reload_from_run");
    build_frame(16, 0);
    run_frame("reload_new", 2);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    pulse_reload();
    build_frame(8, 0);
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      send_byte(frame[i], 0, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL midrst accept: byte %0d got not accepted want accepted", i);
      end
    end
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_wdata !== frame[4] || bus.mem_addr !== ADDR_W'(2)) begin
      n_bad++;
      $display("FAIL midrst pending write: got we=%b data=%h addr=%0d want 1 %h 2",
               bus.mem_we, bus.mem_wdata, bus.mem_addr, frame[4]);
    end
    #1 rst = 1'b1;
    #1;
    check_loader_idle("midrst async");
    n_cmp++;
    if (bus.mem_wdata !== 8'h00 || wr_a.size() !== 2) begin
      n_bad++; $display("FAIL midrst state: got wdata=%h writes=%0d want 00 2", bus.mem_wdata, wr_a.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    build_frame(12, 0);
    run_frame("after_rst", 0);
  endtask

  task automatic test_random();
    int n;
    bit corrupt;
    for (int k = 0; k < 8; k++) begin
      pulse_reload();
      if ($urandom_range(0, 4) == 0) n = 4 * int'($urandom_range(0, 8)) + int'($urandom_range(1, 3));
      else                           n = 4 * int'($urandom_range(0, 16));
      corrupt = ($urandom_range(0, 2) == 0);
      bus.fetch_addr = $urandom;
      build_frame(n, corrupt);
      run_frame($sformatf("random%0d", k), 2);
    end
  endtask

  task automatic test_boundary();
    pulse_reload();
    build_frame(MEM_BYTES, 0);
    run_frame("full_mem", 0);
    n_cmp++;
    if (wr_a.size() == 0 || wr_a[wr_a.size() - 1] !== ADDR_W'(MEM_BYTES - 1)) begin
      n_bad++;
      $display("FAIL full_mem last addr: got %0d want %0d",
               (wr_a.size() == 0) ? -1 : int'(wr_a[wr_a.size() - 1]), MEM_BYTES - 1);
    end
    pulse_reload();
    build_frame(MEM_BYTES + 4, 0);
    run_frame("over_mem", 0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.reload     = 1'b0;
    bus.fetch_addr = '0;
    test_reset();
    test_basic();
    test_toggle();
    test_hdr_err();
    test_bad_chk();
    test_empty_and_reload();
    test_reset_mid_load();
    test_random();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
